// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: command sequencer in front of reg_mem.
// Turns single and burst write/read commands into reg_mem accesses and
// returns read data over a valid/ready response channel. Burst fill writes an
// incrementing data pattern over a wrapping address range.
module mem_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_BITS-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ADDR_BITS:0]    cmd_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_BITS-1:0]  rsp_addr,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAP,
    RSP_WAIT
  } state_t;

  localparam logic [ADDR_BITS-1:0]  ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]    LEN_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]    LEN_ZERO = '0;

  state_t                  state, state_d;
  logic [ADDR_BITS-1:0]    addr_cnt, addr_d;
  logic [DATA_WIDTH-1:0]   data_cnt, data_d;
  logic [ADDR_BITS:0]      remaining, rem_d;
  logic [ADDR_BITS-1:0]    mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_d;
  logic                    mem_wen_d;
  logic                    rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_d;
  logic [ADDR_BITS-1:0]    rsp_addr_d;
  logic                    done_d;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register; reset returns to IDLE, aborting any command in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and next-output logic. Memory-side outputs are computed one
  // cycle ahead so that the registered mem_* values line up with the state
  // that owns them (e.g. mem_addr is already valid during RD_ISSUE).
  always_comb begin
    state_d     = state;
    addr_d      = addr_cnt;
    data_d      = data_cnt;
    rem_d       = remaining;
    mem_addr_d  = mem_addr;
    mem_data_d  = mem_data_in;
    mem_wen_d   = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_addr_d  = rsp_addr;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          data_d = cmd_data;
          rem_d  = cmd_op[1] ? cmd_len : LEN_ONE;
          if (cmd_op[1] && (cmd_len == LEN_ZERO)) begin
            done_d = 1'b1;
          end else if (!cmd_op[0]) begin
            state_d    = WR;
            mem_wen_d  = 1'b1;
            mem_addr_d = cmd_addr;
            mem_data_d = cmd_data;
          end else begin
            state_d    = RD_ISSUE;
            mem_addr_d = cmd_addr;
          end
        end
      end
      WR: begin
        rem_d = remaining - LEN_ONE;
        if (remaining == LEN_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d     = addr_cnt + ADDR_ONE;
          data_d     = data_cnt + DATA_ONE;
          mem_addr_d = addr_cnt + ADDR_ONE;
          mem_data_d = data_cnt + DATA_ONE;
          mem_wen_d  = 1'b1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        rsp_data_d  = mem_data_out;
        rsp_addr_d  = addr_cnt;
        rsp_valid_d = 1'b1;
        state_d     = RSP_WAIT;
      end
      RSP_WAIT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          addr_d      = addr_cnt + ADDR_ONE;
          rem_d       = remaining - LEN_ONE;
          if (remaining == LEN_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = RD_ISSUE;
            mem_addr_d = addr_cnt + ADDR_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counters and registered outputs; reset drops any pending response and
  // deasserts the write enable on the reset edge itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt    <= '0;
      data_cnt    <= '0;
      remaining   <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_wen     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      done        <= 1'b0;
    end else begin
      addr_cnt    <= addr_d;
      data_cnt    <= data_d;
      remaining   <= rem_d;
      mem_addr    <= mem_addr_d;
      mem_data_in <= mem_data_d;
      mem_wen     <= mem_wen_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_addr    <= rsp_addr_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: directed self-checking bench for mem_seq_ctrl with a
// behavioural reg_mem attached to its memory port.
module tb_mem_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [5:0] cmd_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [4:0] rsp_addr;
  logic       done;
  logic       busy;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic [7:0] mem_data_out;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];

  logic [4:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [4:0] rd_addr_q [$];
  logic [7:0] rd_data_q [$];
  int         done_count = 0;

  int checks   = 0;
  int failures = 0;

  mem_seq_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_len      (cmd_len),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_addr     (rsp_addr),
    .done         (done),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wen      (mem_wen),
    .mem_data_out (mem_data_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural reg_mem: registered read, write on the rising edge.
  always @(posedge clk) begin
    mem_data_out <= mem[mem_addr];
    if (mem_wen) mem[mem_addr] = mem_data_in;
  end

  // Log every memory write, every response handshake and every done pulse.
  always @(posedge clk) begin
    if (mem_wen) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data_in);
    end
    if (rsp_valid && rsp_ready) begin
      rd_addr_q.push_back(rsp_addr);
      rd_data_q.push_back(rsp_data);
    end
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until it is accepted; returns just after
  // the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr,
                               input logic [7:0] data, input logic [5:0] len);
    int n;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    int n;
    n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    cycles = n;
  endtask

  initial begin
    int n;
    int wb;
    int rb;
    int db;
    int td;
    int bad;
    logic [7:0] hold_data;
    logic [4:0] hold_addr;
    logic [4:0] wrap_addr [4];
    logic [7:0] wrap_data [4];
    logic [4:0] seq_addr [5];
    logic [7:0] seq_data [5];

    wrap_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    wrap_data = '{8'd254, 8'd255, 8'd0, 8'd1};
    seq_addr  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20};
    seq_data  = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h55};

    for (int i = 0; i < 32; i++) begin
      mem[i]     = 8'(8'h80 + i);
      ref_mem[i] = 8'(8'h80 + i);
    end
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    rsp_ready = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_mem_wen", mem_wen, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data_in", mem_data_in, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_addr", rsp_addr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_cmd_ready", cmd_ready, 1);

    // Single write addr 12 data 10
    wb = wr_addr_q.size(); db = done_count;
    applyStimulus(2'b00, 5'd12, 8'd10, 6'd0);
    checkOutput("sw_mem_wen", mem_wen, 1);
    checkOutput("sw_mem_addr", mem_addr, 12);
    checkOutput("sw_mem_data_in", mem_data_in, 10);
    checkOutput("sw_busy", busy, 1);
    checkOutput("sw_cmd_ready", cmd_ready, 0);
    waitDone(n);
    checkOutput("sw_cycles", n, 1);
    checkOutput("sw_wen_at_done", mem_wen, 0);
    tick();
    checkOutput("sw_done_pulse", done, 0);
    checkOutput("sw_write_count", wr_addr_q.size() - wb, 1);
    checkOutput("sw_write_addr", wr_addr_q[wb], 12);
    checkOutput("sw_write_data", wr_data_q[wb], 10);
    checkOutput("sw_done_count", done_count - db, 1);
    ref_mem[12] = 8'd10;

    // Single read addr 12: response appears on the third edge after acceptance
    rsp_ready = 1'b1;
    rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_count;
    applyStimulus(2'b01, 5'd12, 8'hFF, 6'd0);
    checkOutput("sr_valid_c1", rsp_valid, 0);
    tick();
    checkOutput("sr_valid_c2", rsp_valid, 0);
    tick();
    checkOutput("sr_valid_c3", rsp_valid, 1);
    checkOutput("sr_rsp_data", rsp_data, 10);
    checkOutput("sr_rsp_addr", rsp_addr, 12);
    waitDone(n);
    checkOutput("sr_done_after_hs", n, 1);
    tick();
    checkOutput("sr_rsp_count", rd_addr_q.size() - rb, 1);
    checkOutput("sr_no_write", wr_addr_q.size() - wb, 0);
    checkOutput("sr_done_count", done_count - db, 1);

    // Full fill addr 0 data 10 len 32
    wb = wr_addr_q.size();
    applyStimulus(2'b10, 5'd0, 8'd10, 6'd32);
    waitDone(n);
    checkOutput("fill_cycles", n, 32);
    tick();
    checkOutput("fill_write_count", wr_addr_q.size() - wb, 32);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("fill_addr_%0d", i), wr_addr_q[wb+i], i);
      checkOutput($sformatf("fill_data_%0d", i), wr_data_q[wb+i], 10 + i);
      ref_mem[i] = 8'(10 + i);
    end

    // Full burst readback, one response every three cycles
    rb = rd_addr_q.size();
    applyStimulus(2'b11, 5'd0, 8'd0, 6'd32);
    waitDone(n);
    checkOutput("rdall_cycles", n, 96);
    tick();
    checkOutput("rdall_count", rd_addr_q.size() - rb, 32);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("rdall_addr_%0d", i), rd_addr_q[rb+i], i);
      checkOutput($sformatf("rdall_data_%0d", i), rd_data_q[rb+i], 10 + i);
    end

    // Address and data wrap
    wb = wr_addr_q.size();
    applyStimulus(2'b10, 5'd30, 8'd254, 6'd4);
    waitDone(n);
    checkOutput("wrapfill_cycles", n, 4);
    tick();
    checkOutput("wrapfill_count", wr_addr_q.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrapfill_addr_%0d", i), wr_addr_q[wb+i], wrap_addr[i]);
      checkOutput($sformatf("wrapfill_data_%0d", i), wr_data_q[wb+i], wrap_data[i]);
      ref_mem[wrap_addr[i]] = wrap_data[i];
    end
    rb = rd_addr_q.size();
    applyStimulus(2'b11, 5'd30, 8'd0, 6'd4);
    waitDone(n);
    checkOutput("wrapread_cycles", n, 12);
    tick();
    checkOutput("wrapread_count", rd_addr_q.size() - rb, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrapread_addr_%0d", i), rd_addr_q[rb+i], wrap_addr[i]);
      checkOutput($sformatf("wrapread_data_%0d", i), rd_data_q[rb+i], wrap_data[i]);
    end

    // Backpressure: burst read addr 5 len 3, consumer stalls 5 cycles per word
    rsp_ready = 1'b0;
    rb = rd_addr_q.size(); db = done_count;
    applyStimulus(2'b11, 5'd5, 8'd0, 6'd3);
    for (int w = 0; w < 3; w++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin
        tick();
        n++;
      end
      checkOutput($sformatf("bp_valid_%0d", w), rsp_valid, 1);
      hold_data = rsp_data;
      hold_addr = rsp_addr;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (rsp_valid !== 1'b1 || rsp_data !== hold_data || rsp_addr !== hold_addr ||
            busy !== 1'b1 || cmd_ready !== 1'b0) bad++;
      end
      checkOutput($sformatf("bp_hold_%0d", w), bad, 0);
      checkOutput($sformatf("bp_data_%0d", w), hold_data, 15 + w);
      checkOutput($sformatf("bp_addr_%0d", w), hold_addr, 5 + w);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput($sformatf("bp_valid_drop_%0d", w), rsp_valid, 0);
    end
    checkOutput("bp_done", done, 1);
    tick();
    checkOutput("bp_rsp_count", rd_addr_q.size() - rb, 3);
    checkOutput("bp_done_count", done_count - db, 1);

    // Reset during a fill: words 0..4 land, the reset edge stops everything
    wb = wr_addr_q.size();
    applyStimulus(2'b10, 5'd0, 8'h40, 6'd32);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_wen", mem_wen, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_cmd_ready", cmd_ready, 1);
    checkOutput("mid_rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rst_wen_after", mem_wen, 0);
    checkOutput("mid_rst_write_count", wr_addr_q.size() - wb, 5);
    for (int i = 0; i < 5; i++) ref_mem[i] = 8'(8'h40 + i);
    rsp_ready = 1'b1;
    rb = rd_addr_q.size();
    applyStimulus(2'b11, 5'd5, 8'd0, 6'd27);
    waitDone(n);
    checkOutput("mid_rst_read_cycles", n, 81);
    tick();
    checkOutput("mid_rst_read_count", rd_addr_q.size() - rb, 27);
    for (int i = 0; i < 27; i++) begin
      checkOutput($sformatf("mid_rst_data_%0d", 5 + i), rd_data_q[rb+i], ref_mem[5+i]);
    end

    // Zero-length fill: done only, no memory access
    wb = wr_addr_q.size(); db = done_count;
    applyStimulus(2'b10, 5'd3, 8'h99, 6'd0);
    checkOutput("zl_done", done, 1);
    checkOutput("zl_busy", busy, 0);
    checkOutput("zl_wen", mem_wen, 0);
    tick();
    checkOutput("zl_done_drop", done, 0);
    checkOutput("zl_no_write", wr_addr_q.size() - wb, 0);
    checkOutput("zl_done_count", done_count - db, 1);

    // Busy rejection: second command held during a 4-word fill
    wb = wr_addr_q.size(); db = done_count;
    applyStimulus(2'b10, 5'd10, 8'h70, 6'd4);
    cmd_op    = 2'b00;
    cmd_addr  = 5'd20;
    cmd_data  = 8'h55;
    cmd_len   = 6'd0;
    cmd_valid = 1'b1;
    td = 0;
    for (int k = 1; k <= 20 && td == 0; k++) begin
      tick();
      if (done) td = k;
    end
    checkOutput("busy_done_cycle", td, 4);
    checkOutput("busy_ready_at_done", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("busy_second_wen", mem_wen, 1);
    checkOutput("busy_second_addr", mem_addr, 20);
    checkOutput("busy_second_data", mem_data_in, 8'h55);
    waitDone(n);
    checkOutput("busy_second_cycles", n, 1);
    tick();
    checkOutput("busy_write_count", wr_addr_q.size() - wb, 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("busy_addr_%0d", i), wr_addr_q[wb+i], seq_addr[i]);
      checkOutput($sformatf("busy_data_%0d", i), wr_data_q[wb+i], seq_data[i]);
    end
    checkOutput("busy_done_count", done_count - db, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
Command sequencer that sits directly upstream of reg_mem and is the only block that drives its port.
- Accepts single or burst write/read commands on a valid/ready interface.
- Drives reg_mem addr/data_in/wen.
- Returns read data on a valid/ready response channel.
- Burst fill writes an incrementing data pattern over a wrapping address range, the same pattern used to initialise and check the memory.

Parameters:
DATA_WIDTH, 8, width of memory word and command/response data
ADDR_BITS, 5, memory address width (2^ADDR_BITS words)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 single write, 01 single read, 10 burst fill, 11 burst read
cmd_addr  in  ADDR_BITS  start address
cmd_data  in  DATA_WIDTH  write data, or base value for fill
cmd_len  in  ADDR_BITS+1  burst length, 0..2^ADDR_BITS; ignored for single ops
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_WIDTH  read data
rsp_addr  out  ADDR_BITS  address the read data came from
done  out  1  one-cycle pulse when a command completes
busy  out  1  high whenever the state is not IDLE
mem_addr  out  ADDR_BITS  to reg_mem addr
mem_data_in  out  DATA_WIDTH  to reg_mem data_in
mem_wen  out  1  to reg_mem wen
mem_data_out  in  DATA_WIDTH  from reg_mem data_out

Behaviour:
- Attached memory timing:
  - reg_mem writes mem_data_in to mem_addr on the rising clk edge when mem_wen=1.
  - mem_data_out is registered and valid one cycle after mem_addr is presented with mem_wen=0.
- Reset: when rst_n=0 at a rising edge, the following take effect on that edge:
  - state=IDLE
  - mem_wen=0, mem_addr=0, mem_data_in=0
  - rsp_valid=0, rsp_data=0, rsp_addr=0
  - done=0, busy=0
  - cmd_ready=1 from the first cycle after reset
- Mid-operation reset aborts the command. Any pending response is dropped and no further memory write occurs.
- All mem_* and rsp_* outputs are registered. cmd_ready = (state==IDLE); it is combinational from state.
- Command accepted on an edge where cmd_valid & cmd_ready. On acceptance the controller latches:
  - addr counter = cmd_addr
  - data counter = cmd_data
  - remaining = 1 for single ops, cmd_len for burst ops
- States:
  - IDLE
    - On acceptance with remaining=0 (burst, len 0): stay in IDLE, pulse done next cycle, no memory access.
    - Write op → WR. Read op → RD_ISSUE.
  - WR
    - mem_wen=1 with mem_addr/mem_data_in = counters for exactly one cycle per word; one word written per cycle.
    - After each word: addr += 1 mod 2^ADDR_BITS, data += 1 mod 2^DATA_WIDTH (fill only), remaining -= 1.
    - On the last word → IDLE with mem_wen=0 and done=1 in the same following cycle.
    - Single write of N words takes N cycles in WR.
  - RD_ISSUE: mem_addr = addr counter, mem_wen=0, one cycle → RD_CAP.
  - RD_CAP: capture mem_data_out into rsp_data and the addr into rsp_addr, set rsp_valid=1 → RSP_WAIT.
  - RSP_WAIT
    - Hold rsp_valid/rsp_data/rsp_addr stable until rsp_ready=1.
    - On handshake: rsp_valid=0, addr += 1 mod 2^ADDR_BITS, remaining -= 1.
    - If remaining becomes 0 → IDLE with done=1. Otherwise → RD_ISSUE.
- Read timing:
  - rsp_valid rises 3 cycles after command acceptance.
  - With rsp_ready held at 1, a burst read delivers one word every 3 cycles.
- Address wrap: start 30, len 4 → addresses 30,31,0,1.
- Data wrap: base 254 → 254,255,0,1.
- cmd_len=2^ADDR_BITS covers every address exactly once; no word is written twice.
- A command presented while busy is not accepted; cmd_ready=0 and it stays pending upstream.
- rsp_ready=1 while rsp_valid=0 has no effect.
- done is never asserted together with cmd_ready of a new acceptance in the same edge from the same command; done follows the return to IDLE.

Test Plan:
- Reset then single write: op 00, addr 12, data 10, then single read addr 12 → exactly one mem_wen cycle at addr 12; rsp_data=10, rsp_addr=12; rsp_valid 3 cycles after read acceptance; done pulses once per command.
- Full fill and readback: op 10, addr 0, data 10, len 32 → 32 consecutive mem_wen cycles writing 10..41 to addresses 0..31; then op 11, addr 0, len 32 with rsp_ready=1 → responses 10..41 in order, one every 3 cycles.
- Wrap: fill addr 30, data 254, len 4, then burst read addr 30, len 4 → responses (30,254),(31,255),(0,0),(1,1).
- Backpressure: burst read len 3 with rsp_ready held low 5 cycles per word → rsp_valid/rsp_data stay stable while waiting; exactly 3 responses, no skipped or duplicated words; busy=1 and cmd_ready=0 throughout.
- Reset mid-burst: fill addr 0, len 32, assert rst_n=0 after 5 write cycles → mem_wen=0 from the reset edge; then reading addresses 5..31 returns the pre-fill contents; cmd_ready=1 after reset.
- Zero length and busy rejection: burst fill with len 0 → no mem_wen, done pulses once. A command held on cmd_valid during a burst → accepted only on the cycle after done.
